// File: rtl/fifo_sync_param_if.sv
// Producer/consumer handshake bundle for fifo_sync_param.
// master = the logic that pushes and pops; slave = the FIFO itself.
interface fifo_sync_param_if #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             wr_enb;
    logic             rd_enb;
    logic [WIDTH-1:0] data_in;
    logic             err_clr;
    logic [WIDTH-1:0] data_out;
    logic             valid_out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic             almost_empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr_enb, rd_enb, data_in, err_clr,
        input  data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );

    modport slave (
        input  wr_enb, rd_enb, data_in, err_clr,
        output data_out, valid_out, full, empty, almost_full, almost_empty,
               count, overflow, underflow
    );
endinterface

// File: rtl/fifo_sync_param.sv
// Parametrised single-clock FIFO with count, almost flags and sticky errors.
// Define FIFO_FWFT_EN for first-word fall-through reads; default is 1-cycle read latency.
module fifo_sync_param #(
    parameter int WIDTH  = 10,
    parameter int DEPTH  = 8,
    parameter int AF_LVL = 6,
    parameter int AE_LVL = 2
) (
    input logic               clk,
    input logic               rst,
    fifo_sync_param_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam int CNT_W  = ADDR_W + 1;

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic [CNT_W-1:0]  count_q;
    logic              overflow_q;
    logic              underflow_q;
    logic              full;
    logic              empty;
    logic              rd_acc;
    logic              wr_acc;

    assign full   = (count_q == CNT_W'(DEPTH));
    assign empty  = (count_q == '0);
    // A write into a full FIFO is still taken when a read frees a slot this cycle.
    assign rd_acc = bus.rd_enb & ~empty;
    assign wr_acc = bus.wr_enb & (~full | rd_acc);

    // NOTE: storage has no reset; stale words are unreachable because count/pointers are.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[wr_ptr[ADDR_W-1:0]] <= bus.data_in;
    end

    // NOTE: all state uses non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            case ({wr_acc, rd_acc})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // A fresh error outranks a clear in the same cycle.
            if (bus.wr_enb & full & ~rd_acc) overflow_q <= 1'b1;
            else if (bus.err_clr)            overflow_q <= 1'b0;
            if (bus.rd_enb & empty)          underflow_q <= 1'b1;
            else if (bus.err_clr)            underflow_q <= 1'b0;
        end
    end

`ifdef FIFO_FWFT_EN
    logic [WIDTH-1:0] head;

    // NOTE: every comb output gets a default first so no latch is inferred.
    always_comb begin
        head = '0;
        if (!empty) head = mem[rd_ptr[ADDR_W-1:0]];
    end

    assign bus.data_out  = head;
    assign bus.valid_out = ~empty;
`else
    logic [WIDTH-1:0] data_q;
    logic             valid_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= rd_acc;
            if (rd_acc) data_q <= mem[rd_ptr[ADDR_W-1:0]];
        end
    end

    assign bus.data_out  = data_q;
    assign bus.valid_out = valid_q;
`endif

    assign bus.full         = full;
    assign bus.empty        = empty;
    assign bus.almost_full  = (count_q >= CNT_W'(AF_LVL));
    assign bus.almost_empty = (count_q <= CNT_W'(AE_LVL));
    assign bus.count        = count_q;
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_fifo_sync_param.sv
// Directed self-checking bench for fifo_sync_param (WIDTH 10, DEPTH 8, AF 6, AE 2).
// Read checks follow whichever read mode FIFO_FWFT_EN selects.
module tb_fifo_sync_param;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;

    fifo_sync_param_if #(.WIDTH(10), .DEPTH(8)) bus ();

    fifo_sync_param #(.WIDTH(10), .DEPTH(8), .AF_LVL(6), .AE_LVL(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [9:0] d);
        bus.wr_enb  = 1'b1;
        bus.data_in = d;
        step();
        bus.wr_enb  = 1'b0;
    endtask

    task automatic pop_check(input string tag, input logic [9:0] exp);
`ifdef FIFO_FWFT_EN
        check({tag, "_head"}, bus.data_out, exp);
        check({tag, "_valid"}, bus.valid_out, 1);
        bus.rd_enb = 1'b1;
        step();
        bus.rd_enb = 1'b0;
`else
        bus.rd_enb = 1'b1;
        step();
        bus.rd_enb = 1'b0;
        check({tag, "_data"}, bus.data_out, exp);
        check({tag, "_valid"}, bus.valid_out, 1);
`endif
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_count"}, bus.count, 0);
        check({tag, "_empty"}, bus.empty, 1);
        check({tag, "_full"}, bus.full, 0);
        check({tag, "_ae"}, bus.almost_empty, 1);
        check({tag, "_af"}, bus.almost_full, 0);
        check({tag, "_valid"}, bus.valid_out, 0);
        check({tag, "_ovf"}, bus.overflow, 0);
        check({tag, "_unf"}, bus.underflow, 0);
`ifndef FIFO_FWFT_EN
        check({tag, "_dout"}, bus.data_out, 0);
`endif
    endtask

    initial begin
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
        bus.data_in = '0;
        bus.err_clr = 1'b0;
        step();
        step();
        check_reset_state("por");
        rst = 1'b1;
        step();

        // Reset in the middle of a burst discards everything.
        push(10'd1);
        push(10'd2);
        bus.wr_enb  = 1'b1;
        bus.data_in = 10'd3;
        check("burst_count", bus.count, 2);
        #2 rst = 1'b0;
        bus.wr_enb = 1'b0;
        #1;
        check_reset_state("midrst");
        step();
        rst = 1'b1;
        step();
        check("post_rst_count", bus.count, 0);

        // Basic ordering and latency.
        push(10'd10);
        push(10'd15);
        push(10'd20);
        check("three_count", bus.count, 3);
        check("three_ae", bus.almost_empty, 0);
        pop_check("rd10", 10'd10);
        pop_check("rd15", 10'd15);
        pop_check("rd20", 10'd20);
        check("drained_empty", bus.empty, 1);
        step();
        check("idle_valid", bus.valid_out, 0);
`ifndef FIFO_FWFT_EN
        check("idle_hold", bus.data_out, 20);
`endif

        // Fill, thresholds, overflow and clear.
        for (int i = 1; i <= 8; i++) begin
            push(10'(30 + i));
            check($sformatf("fill%0d_count", i), bus.count, i);
            check($sformatf("fill%0d_af", i), bus.almost_full, (i >= 6));
            check($sformatf("fill%0d_full", i), bus.full, (i == 8));
        end
        push(10'd500);
        check("ovf_flag", bus.overflow, 1);
        check("ovf_count", bus.count, 8);
        bus.err_clr = 1'b1;
        step();
        bus.err_clr = 1'b0;
        check("ovf_clr", bus.overflow, 0);

        // Full with simultaneous read and write: both taken.
`ifdef FIFO_FWFT_EN
        check("fullrw_head", bus.data_out, 31);
`endif
        bus.wr_enb  = 1'b1;
        bus.rd_enb  = 1'b1;
        bus.data_in = 10'd99;
        step();
        bus.wr_enb  = 1'b0;
        bus.rd_enb  = 1'b0;
`ifndef FIFO_FWFT_EN
        check("fullrw_data", bus.data_out, 31);
`endif
        check("fullrw_count", bus.count, 8);
        check("fullrw_full", bus.full, 1);
        check("fullrw_ovf", bus.overflow, 0);
        for (int i = 2; i <= 8; i++) pop_check($sformatf("drain%0d", i), 10'(30 + i));
        pop_check("drain99", 10'd99);
        check("drain_empty", bus.empty, 1);

        // Underflow, and a new error winning over err_clr.
        bus.rd_enb = 1'b1;
        step();
        bus.rd_enb = 1'b0;
        check("unf_flag", bus.underflow, 1);
        check("unf_valid", bus.valid_out, 0);
        check("unf_count", bus.count, 0);
        bus.rd_enb  = 1'b1;
        bus.err_clr = 1'b1;
        step();
        bus.rd_enb  = 1'b0;
        check("unf_wins", bus.underflow, 1);
        step();
        bus.err_clr = 1'b0;
        check("unf_clr", bus.underflow, 0);

        // Streaming pairs across the pointer wrap.
        push(10'd10);
        for (int i = 1; i < 20; i++) begin
`ifdef FIFO_FWFT_EN
            check($sformatf("strm%0d_head", i), bus.data_out, 10 + 5 * (i - 1));
`endif
            bus.wr_enb  = 1'b1;
            bus.rd_enb  = 1'b1;
            bus.data_in = 10'(10 + 5 * i);
            step();
`ifndef FIFO_FWFT_EN
            check($sformatf("strm%0d_data", i), bus.data_out, 10 + 5 * (i - 1));
`endif
            check($sformatf("strm%0d_count", i), bus.count, 1);
        end
        bus.wr_enb = 1'b0;
        bus.rd_enb = 1'b0;
        pop_check("strm_last", 10'd105);
        check("strm_ovf", bus.overflow, 0);
        check("strm_unf", bus.underflow, 0);
        check("strm_empty", bus.empty, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
